clk_edge_tracker: RTL and testbench
===================================

CLK_EDGE_TRACKER -- requirements
Module: clk_edge_tracker

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the period counter and of o_period.
REQ-002 SHALL have parameter: LOCK_CNT, 4, number of consecutive equal period measurements needed for lock.
REQ-003 SHALL have port: i_clk  input  1  system clock, the only clock.
REQ-004 SHALL have port: i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: i_div_clk  input  1  divided-clock level, generated synchronously to i_clk.
REQ-006 SHALL have port: i_err_clr  input  1  clears o_err.
REQ-007 SHALL have port: o_rise_stb  output  1  one-cycle pulse per i_div_clk rising edge.
REQ-008 SHALL have port: o_fall_stb  output  1  one-cycle pulse per i_div_clk falling edge.
REQ-009 SHALL have port: o_period  output  CNT_W  last measured rise-to-rise period, in i_clk cycles.
REQ-010 SHALL have port: o_locked  output  1  period stable for LOCK_CNT measurements.
REQ-011 SHALL have port: o_err  output  1  sticky flag for a period change or timeout seen while locked.

Function
REQ-012 SHALL register i_div_clk every i_clk edge into a sample flop s; no synchronizer stages.
REQ-013 SHALL set o_rise_stb <= i_div_clk & ~s, so the strobe is registered with 1-cycle latency and high for exactly one cycle.
REQ-014 SHALL set o_fall_stb <= ~i_div_clk & s when fall detection is compiled in (REQ-026).
REQ-015 SHALL run a period counter cnt that reloads to 1 on each detected rise, else increments, saturating at 2^CNT_W-1.
REQ-016 SHALL implement the state machine with states SEARCH, MEASURE and LOCKED.
REQ-017 SHALL act in SEARCH as follows: on the first rise, go to MEASURE, reload cnt, clear the match count, leave o_period unchanged.
REQ-018 SHALL act in MEASURE, on each rise, as follows: o_period <= cnt; if cnt equals the previous o_period, increment the match count, else set it to 0.
REQ-019 SHALL go from MEASURE to LOCKED with o_locked <= 1 on the rise whose match makes the count reach LOCK_CNT-1.
REQ-020 SHALL define the lock point as the LOCK_CNT-th consecutive equal period measurement, i.e. LOCK_CNT+1 rises after SEARCH.
REQ-021 SHALL act in LOCKED, on a rise with cnt != o_period, as follows: o_err <= 1, o_locked <= 0, o_period <= cnt, match count <= 0, next state MEASURE.
REQ-022 SHALL, when cnt saturates in MEASURE or LOCKED, go to SEARCH with o_locked <= 0, and set o_err only if the state was LOCKED.
REQ-023 SHALL clear o_err on i_err_clr; if set and clear occur in the same cycle, set wins.
REQ-024 SHALL treat a constant i_div_clk as producing no strobes; the timeout path handles it.

Reset
REQ-025 SHALL, when i_rst is sampled high, give all outputs 0 (o_period=0), s=0, cnt=0, match count=0, state SEARCH; reset SHALL abort any measurement, and the first rise after reset SHALL follow REQ-017.

Configuration
REQ-026 SHALL use macro CLK_EDGE_TRACKER_FALL_EN: when defined, o_fall_stb follows REQ-014; when undefined, o_fall_stb is tied 0 and its logic is omitted. Rise, period and lock behaviour SHALL be identical in both builds.

Verification
REQ-027 SHALL cover: i_div_clk = divide-by-4 pattern 0,0,1,1 repeating -> o_rise_stb pulses every 4 cycles, 1 cycle after the sampled 0->1 transition; o_period=4.
REQ-028 SHALL cover: divide-by-4 from reset, LOCK_CNT=4 -> o_locked rises on the same edge as the 5th o_rise_stb; o_err stays 0.
REQ-029 SHALL cover: locked at period 4, then one high phase stretched to give period 6 -> o_err=1, o_locked=0, o_period=6; relock occurs after 4 further equal periods.
REQ-030 SHALL cover: locked, then i_div_clk held at 1 for 300 cycles with CNT_W=8 -> SEARCH at cnt=255, o_locked=0, o_err=1; o_err persists until i_err_clr, and same-cycle set+clear leaves o_err=1.
REQ-031 SHALL cover: divide-by-2 toggling -> o_period=2; with CLK_EDGE_TRACKER_FALL_EN, o_rise_stb and o_fall_stb alternate every cycle; without it, o_fall_stb=0.
REQ-032 SHALL cover: i_rst asserted mid-MEASURE for 1 cycle -> the next cycle shows all outputs 0 and state SEARCH, and lock needs 5 new rises.

Source files
------------

// File: rtl/clk_edge_tracker.sv
// clk_edge_tracker: watches a divided-clock level generated in the i_clk
// domain, emits edge strobes, measures the rise-to-rise period and reports
// lock once the period has been stable for LOCK_CNT measurements.
//
// Build option: define CLK_EDGE_TRACKER_FALL_EN to enable the falling-edge
// strobe. When it is undefined, o_fall_stb is tied to 0.
//
// Ports:
//   i_clk       system clock (only clock)
//   i_rst       synchronous active-high reset
//   i_div_clk   divided-clock level, synchronous to i_clk
//   i_err_clr   clears o_err (a same-cycle set takes priority)
//   o_rise_stb  one-cycle pulse per i_div_clk rising edge
//   o_fall_stb  one-cycle pulse per i_div_clk falling edge (optional)
//   o_period    last measured rise-to-rise period in i_clk cycles
//   o_locked    period stable for LOCK_CNT measurements
//   o_err       sticky: period change or timeout seen while locked
module clk_edge_tracker #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_div_clk,
  input  logic             i_err_clr,
  output logic             o_rise_stb,
  output logic             o_fall_stb,
  output logic [CNT_W-1:0] o_period,
  output logic             o_locked,
  output logic             o_err
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [MW-1:0]    MATCH_LOCK = MW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic             r_s;
  logic [CNT_W-1:0] r_cnt;
  logic [MW-1:0]    r_match;
  state_t           r_state;

  logic             w_rise;
  logic             w_sat;
  logic             w_cnt_eq;
  logic [MW-1:0]    w_match_inc;
  state_t           w_state_nxt;
  logic [MW-1:0]    w_match_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic             w_locked_nxt;
  logic             w_err_set;

  // Edge detect against the previous sample; no synchronizer needed since
  // i_div_clk is produced in this clock domain.
  assign w_rise      = i_div_clk & ~r_s;
  assign w_sat       = (r_cnt == CNT_MAX);
  assign w_cnt_eq    = (r_cnt == o_period);
  assign w_match_inc = r_match + MW'(1);

  // Next-state and registered-output decode. A rise takes priority over a
  // simultaneous saturation, so a 2^CNT_W-1 period is still measured.
  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match;
    w_period_nxt = o_period;
    w_locked_nxt = o_locked;
    w_err_set    = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
          w_match_nxt = '0;
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_period_nxt = r_cnt;
          if (w_cnt_eq) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc >= MATCH_LOCK) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_match_nxt = '0;
          end
        end else if (w_sat) begin
          w_state_nxt  = ST_SEARCH;
          w_locked_nxt = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (w_rise) begin
          if (!w_cnt_eq) begin
            w_err_set    = 1'b1;
            w_locked_nxt = 1'b0;
            w_period_nxt = r_cnt;
            w_match_nxt  = '0;
            w_state_nxt  = ST_MEASURE;
          end
        end else if (w_sat) begin
          w_err_set    = 1'b1;
          w_locked_nxt = 1'b0;
          w_state_nxt  = ST_SEARCH;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  // State, period counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s        <= 1'b0;
      r_cnt      <= '0;
      r_match    <= '0;
      r_state    <= ST_SEARCH;
      o_rise_stb <= 1'b0;
      o_period   <= '0;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      r_s <= i_div_clk;
      if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (!w_sat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_match    <= w_match_nxt;
      r_state    <= w_state_nxt;
      o_rise_stb <= w_rise;
      o_period   <= w_period_nxt;
      o_locked   <= w_locked_nxt;
      // Set beats clear when both happen in the same cycle.
      o_err      <= w_err_set | (o_err & ~i_err_clr);
    end
  end

`ifdef CLK_EDGE_TRACKER_FALL_EN
  logic w_fall;
  assign w_fall = ~i_div_clk & r_s;

  // Falling-edge strobe, same 1-cycle latency as the rise strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fall_stb <= 1'b0;
    end else begin
      o_fall_stb <= w_fall;
    end
  end
`else
  assign o_fall_stb = 1'b0;
`endif

endmodule

// File: tb/tb_clk_edge_tracker.sv
// Testbench for clk_edge_tracker: reset/lock vector table, directed
// corner sequences, then random stimulus against a timestamp-based model.
module tb_clk_edge_tracker;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LOCK_CNT = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef CLK_EDGE_TRACKER_FALL_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  localparam int M_SEARCH  = 0;
  localparam int M_MEASURE = 1;
  localparam int M_LOCKED  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             div = 1'b0;
  logic             clr = 1'b0;
  logic             o_rise_stb;
  logic             o_fall_stb;
  logic [CNT_W-1:0] o_period;
  logic             o_locked;
  logic             o_err;

  clk_edge_tracker #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_div_clk  (div),
    .i_err_clr  (clr),
    .o_rise_stb (o_rise_stb),
    .o_fall_stb (o_fall_stb),
    .o_period   (o_period),
    .o_locked   (o_locked),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the counter value is derived from the edge index of
  // the last rise (or reset), and lock from the run of equal periods.
  int m_edge   = 0;
  int m_origin = 0;
  bit m_s      = 1'b0;
  int m_mode   = M_SEARCH;
  int m_hist[$];
  int m_period = 0;
  bit m_locked = 1'b0;
  bit m_err    = 1'b0;
  bit m_rise   = 1'b0;
  bit m_fall   = 1'b0;

  function automatic int trailing_run();
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] == m_hist[m_hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic void model_edge(input bit d, input bit r, input bit c);
    int cnt;
    bit rise;
    bit fall;
    bit set_err;
    m_edge++;
    if (r) begin
      m_s      = 1'b0;
      m_origin = m_edge + 1;
      m_mode   = M_SEARCH;
      m_hist.delete();
      m_period = 0;
      m_locked = 1'b0;
      m_err    = 1'b0;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      return;
    end
    rise    = d & ~m_s;
    fall    = ~d & m_s;
    set_err = 1'b0;
    cnt     = m_edge - m_origin;
    if (cnt > CNT_MAX) cnt = CNT_MAX;
    case (m_mode)
      M_SEARCH: begin
        if (rise) begin
          m_mode = M_MEASURE;
          m_hist.delete();
          m_hist.push_back(m_period);
        end
      end
      M_MEASURE: begin
        if (rise) begin
          m_period = cnt;
          m_hist.push_back(cnt);
          if (trailing_run() >= LOCK_CNT) begin
            m_mode   = M_LOCKED;
            m_locked = 1'b1;
          end
        end else if (cnt == CNT_MAX) begin
          m_mode   = M_SEARCH;
          m_locked = 1'b0;
        end
      end
      default: begin
        if (rise) begin
          if (cnt != m_period) begin
            set_err  = 1'b1;
            m_locked = 1'b0;
            m_period = cnt;
            m_mode   = M_MEASURE;
            m_hist.delete();
            m_hist.push_back(cnt);
          end
        end else if (cnt == CNT_MAX) begin
          set_err  = 1'b1;
          m_locked = 1'b0;
          m_mode   = M_SEARCH;
        end
      end
    endcase
    if (set_err) m_err = 1'b1;
    else if (c) m_err = 1'b0;
    if (rise) m_origin = m_edge;
    m_s    = d;
    m_rise = rise;
    m_fall = FALL_EN & fall;
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit d, input bit r, input bit c);
    div = d;
    rst = r;
    clr = c;
    model_edge(d, r, c);
    @(posedge clk);
    #1;
    check($sformatf("cyc%0d rise", m_edge), int'(o_rise_stb), int'(m_rise));
    check($sformatf("cyc%0d fall", m_edge), int'(o_fall_stb), int'(m_fall));
    check($sformatf("cyc%0d period", m_edge), int'(o_period), m_period);
    check($sformatf("cyc%0d locked", m_edge), int'(o_locked), int'(m_locked));
    check($sformatf("cyc%0d err", m_edge), int'(o_err), int'(m_err));
  endtask

  // Snapshot of DUT outputs taken right after the rising-edge cycle.
  int sn_rise, sn_period, sn_locked, sn_err;

  task automatic rise_period(input int lo, input int hi, input bit c);
    repeat (lo) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, c);
    sn_rise   = int'(o_rise_stb);
    sn_period = int'(o_period);
    sn_locked = int'(o_locked);
    sn_err    = int'(o_err);
    repeat (hi - 1) step(1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit div;
    bit rst;
    bit clr;
    bit rise;
    int period;
    bit locked;
    bit err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(bit d, bit r, bit c, bit rs, int p, bit l, bit e);
    vec_t v;
    v.div = d; v.rst = r; v.clr = c; v.rise = rs; v.period = p; v.locked = l; v.err = e;
    tbl.push_back(v);
  endfunction

  initial begin
    // Reset, then divide-by-4 (0,0,1,1): lock on the 5th rise strobe.
    add_vec(0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4, 0, 0);
    add_vec(1, 0, 0, 0, 4, 0, 0);
    add_vec(0, 0, 0, 0, 4, 0, 0);
    add_vec(0, 0, 0, 0, 4, 0, 0);
    add_vec(1, 0, 0, 1, 4, 0, 0);
    add_vec(1, 0, 0, 0, 4, 0, 0);
    add_vec(0, 0, 0, 0, 4, 0, 0);
    add_vec(0, 0, 0, 0, 4, 0, 0);
    add_vec(1, 0, 0, 1, 4, 0, 0);
    add_vec(1, 0, 0, 0, 4, 0, 0);
    add_vec(0, 0, 0, 0, 4, 0, 0);
    add_vec(0, 0, 1, 0, 4, 0, 0);
    add_vec(1, 0, 0, 1, 4, 1, 0);
    add_vec(1, 0, 0, 0, 4, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].div, tbl[i].rst, tbl[i].clr);
      check($sformatf("vec%0d rise", i), int'(o_rise_stb), int'(tbl[i].rise));
      check($sformatf("vec%0d period", i), int'(o_period), tbl[i].period);
      check($sformatf("vec%0d locked", i), int'(o_locked), int'(tbl[i].locked));
      check($sformatf("vec%0d err", i), int'(o_err), int'(tbl[i].err));
    end

    // Stretched high phase while locked gives one period of 6.
    rise_period(2, 2, 1'b0);
    check("lock_hold locked", sn_locked, 1);
    rise_period(2, 4, 1'b0);
    rise_period(2, 2, 1'b0);
    check("stretch err", sn_err, 1);
    check("stretch locked", sn_locked, 0);
    check("stretch period", sn_period, 6);
    for (int k = 1; k <= 4; k++) begin
      rise_period(2, 2, 1'b0);
      check($sformatf("relock k%0d locked", k), sn_locked, (k == 4) ? 1 : 0);
      check($sformatf("relock k%0d period", k), sn_period, 4);
    end
    check("relock err sticky", int'(o_err), 1);
    step(1'b0, 1'b0, 1'b1);
    check("err clear", int'(o_err), 0);
    rise_period(1, 2, 1'b0);
    check("after clear locked", sn_locked, 1);

    // Held high while locked: timeout when the counter reaches 255.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 300; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 254) begin
        check("timeout-1 locked", int'(o_locked), 1);
        check("timeout-1 err", int'(o_err), 0);
      end
      if (k == 255) begin
        check("timeout locked", int'(o_locked), 0);
        check("timeout err", int'(o_err), 1);
      end
    end
    check("timeout err persists", int'(o_err), 1);
    check("timeout period kept", int'(o_period), 4);

    // Relock, then a period change with clear in the same cycle: set wins.
    repeat (5) rise_period(2, 2, 1'b0);
    check("relock2 locked", sn_locked, 1);
    check("relock2 err", sn_err, 1);
    rise_period(2, 4, 1'b0);
    rise_period(2, 2, 1'b1);
    check("set+clr err", sn_err, 1);
    check("set+clr locked", sn_locked, 0);
    step(1'b0, 1'b0, 1'b1);
    check("clr after set", int'(o_err), 0);

    // Divide-by-2: rise and fall strobes alternate every cycle.
    repeat (8) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("div2 k%0d fall", k), int'(o_fall_stb), int'(FALL_EN));
      check($sformatf("div2 k%0d no rise", k), int'(o_rise_stb), 0);
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("div2 k%0d rise", k), int'(o_rise_stb), 1);
      check($sformatf("div2 k%0d no fall", k), int'(o_fall_stb), 0);
      check($sformatf("div2 k%0d period", k), int'(o_period), 2);
    end

    // One-cycle reset mid-measurement: outputs clear, 5 new rises to lock.
    rise_period(2, 2, 1'b0);
    rise_period(2, 2, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst rise", int'(o_rise_stb), 0);
    check("rst fall", int'(o_fall_stb), 0);
    check("rst period", int'(o_period), 0);
    check("rst locked", int'(o_locked), 0);
    check("rst err", int'(o_err), 0);
    for (int k = 1; k <= 5; k++) begin
      rise_period(2, 2, 1'b0);
      check($sformatf("post-rst k%0d rise", k), sn_rise, 1);
      check($sformatf("post-rst k%0d locked", k), sn_locked, (k == 5) ? 1 : 0);
    end

    // Random segments: stable periods, random toggles, long holds, resets.
    for (int seg = 0; seg < 200; seg++) begin
      int kind;
      int lo;
      int hi;
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        lo = int'($urandom_range(1, 4));
        hi = int'($urandom_range(1, 4));
        repeat ($urandom_range(3, 8)) rise_period(lo, hi, bit'($urandom_range(0, 7) == 0));
      end else if (kind < 8) begin
        repeat ($urandom_range(5, 30))
          step(bit'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 15) == 0));
      end else if (kind == 8) begin
        bit lvl;
        lvl = bit'($urandom_range(0, 1));
        repeat ($urandom_range(200, 320)) step(lvl, 1'b0, 1'b0);
      end else begin
        step(bit'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
